atto_mem_bridge: RTL and testbench

ATTO_MEM_BRIDGE -- requirements
Module: atto_mem_bridge

---
 rtl/atto_pkg.sv | 16 +
 rtl/atto_wait_counter.sv | 27 ++
 rtl/atto_mem_bridge.sv | 118 +++++++++++
 tb/tb_atto_mem_bridge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/atto_pkg.sv
// Shared types and constants for the atto memory bridge.
package atto_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;

  localparam logic [ADDR_W-1:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SETUP = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/atto_wait_counter.sv
// Wait-state countdown: load a count, decrement each cycle, flag the final cycle.
module atto_wait_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/atto_mem_bridge.sv
// CPU-to-SRAM bus bridge with wait states and an optional memory-mapped output
// register (enabled by defining ATTO_IO_PORT_EN).
module atto_mem_bridge
  import atto_pkg::*;
#(
  parameter int unsigned         WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0]   IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_dir,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] io_out
);

  state_t            state;
  logic              dir_q;
  logic              is_io_q;
  logic              io_hit;
  logic [DATA_W-1:0] io_rd;
  logic              cnt_load;
  logic              cnt_dec;
  logic              wait_last;

`ifdef ATTO_IO_PORT_EN
  logic [DATA_W-1:0] io_reg;

  assign io_hit = (cpu_addr == IO_ADDR);
  assign io_rd  = io_reg;
  assign io_out = io_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_reg <= '0;
    end else if ((state == ST_DONE) && is_io_q && !dir_q) begin
      io_reg <= mem_wdata;
    end
  end
`else
  // IO_ADDR is an ordinary memory address in this build.
  assign io_hit = (cpu_addr == IO_ADDR) & 1'b0;
  assign io_rd  = '0;
  assign io_out = '0;
`endif

  assign cnt_load = (state == ST_SETUP) && !is_io_q && (WAIT_STATES != 0);
  assign cnt_dec  = (state == ST_WAIT);

  atto_wait_counter #(
    .WIDTH (4)
  ) u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (4'(WAIT_STATES)),
    .dec      (cnt_dec),
    .last     (wait_last)
  );

  // SRAM strobes are registered on the edge that enters SETUP and released on
  // the edge that leaves DONE, so they stay valid for the whole access window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      dir_q     <= 1'b0;
      is_io_q   <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            dir_q     <= cpu_dir;
            is_io_q   <= io_hit;
            mem_ce    <= ~io_hit;
            mem_we    <= ~io_hit & ~cpu_dir;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          state <= (is_io_q || (WAIT_STATES == 0)) ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_last) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          cpu_ready <= 1'b1;
          mem_ce    <= 1'b0;
          mem_we    <= 1'b0;
          if (dir_q) begin
            cpu_rdata <= is_io_q ? io_rd : mem_rdata;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atto_mem_bridge.sv
// Scoreboard bench for atto_mem_bridge: instance 0 uses WAIT_STATES=2, instance 1 WAIT_STATES=0.
module tb_atto_mem_bridge;

  typedef struct {
    int         inst;
    logic [7:0] rdata;
    int         lat;
    int         start;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req   [2];
  logic [15:0] addr  [2];
  logic        dir   [2];
  logic [7:0]  wdata [2];
  logic [7:0]  rdata [2];
  logic        ready [2];
  logic [15:0] maddr [2];
  logic        ce    [2];
  logic        we    [2];
  logic [7:0]  mwdata[2];
  logic [7:0]  mrdata[2];
  logic [7:0]  io    [2];

  logic [7:0]  sram      [2][65536];
  logic [7:0]  model_mem [2][65536];
  logic [7:0]  last_rd   [2];
  logic [7:0]  io_model  [2];

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ce_cnt [2];
  int   rdy_cnt[2];
  int   we_viol = 0;
  int   base;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    atto_mem_bridge #(
      .WAIT_STATES ((g == 0) ? 2 : 0),
      .IO_ADDR     (16'hFFFF)
    ) dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_req   (req[g]),
      .cpu_addr  (addr[g]),
      .cpu_dir   (dir[g]),
      .cpu_wdata (wdata[g]),
      .cpu_rdata (rdata[g]),
      .cpu_ready (ready[g]),
      .mem_addr  (maddr[g]),
      .mem_ce    (ce[g]),
      .mem_we    (we[g]),
      .mem_wdata (mwdata[g]),
      .mem_rdata (mrdata[g]),
      .io_out    (io[g])
    );
    assign mrdata[g] = ce[g] ? sram[g][maddr[g]] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_io(input logic [15:0] a);
`ifdef ATTO_IO_PORT_EN
    return a == 16'hFFFF;
`else
    return 1'b0;
`endif
  endfunction

  // Called right after a negedge; returns on the negedge following the sample edge.
  task automatic issue(input int i, input logic d, input logic [15:0] a, input logic [7:0] w);
    exp_t e;
    req[i] = 1'b1; dir[i] = d; addr[i] = a; wdata[i] = w;
    @(posedge clock); #1;
    req[i] = 1'b0;
    e.inst  = i;
    e.start = cyc;
    e.lat   = (is_io(a) || i == 1) ? 3 : 5;
    if (d) begin
      e.rdata = is_io(a) ? io_model[i] : model_mem[i][a];
      last_rd[i] = e.rdata;
    end else begin
      e.rdata = last_rd[i];
      if (is_io(a)) io_model[i] = w;
      else model_mem[i][a] = w;
    end
    sbq.push_back(e);
    @(negedge clock);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sbq.size() != 0; k++) @(negedge clock);
    check("drain", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic xfer(input int i, input logic d, input logic [15:0] a, input logic [7:0] w);
    int b;
    b = rdy_cnt[i];
    ce_cnt[i] = 0;
    issue(i, d, a, w);
    drain();
    check("ce_cycles", ce_cnt[i], is_io(a) ? 0 : ((i == 0) ? 4 : 2));
    check("ready_pulses", rdy_cnt[i] - b, 1);
    check("io_out", io[i], io_model[i]);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; dir[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      last_rd[i] = '0; io_model[i] = '0; ce_cnt[i] = 0; rdy_cnt[i] = 0;
      for (int a = 0; a < 65536; a++) begin
        sram[i][a] = 8'h00;
        model_mem[i][a] = 8'h00;
      end
    end
    sram[0][16'h1234] = 8'hA5; model_mem[0][16'h1234] = 8'hA5;
    sram[1][16'h0001] = 8'h3E; model_mem[1][16'h0001] = 8'h3E;

    fork
      forever begin
        @(posedge clock);
        cyc++;
        for (int i = 0; i < 2; i++)
          if (ce[i] && we[i]) sram[i][maddr[i]] = mwdata[i];
      end
      forever begin
        exp_t e;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
          if (ce[i]) ce_cnt[i]++;
          if (we[i] && !ce[i]) we_viol++;
          if (ready[i]) begin
            rdy_cnt[i]++;
            if (sbq.size() == 0) begin
              check("spurious_ready", 32'(i + 1), 0);
            end else begin
              e = sbq.pop_front();
              check("ready_inst", i, e.inst);
              check("rdata", rdata[i], e.rdata);
              check("latency", cyc - e.start + 1, e.lat);
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clock);
    check("rst_rdata", rdata[0], 8'h00);
    check("rst_ready", ready[0], 1'b0);
    check("rst_ce", ce[0], 1'b0);
    check("rst_we", we[0], 1'b0);
    check("rst_maddr", maddr[0], 16'h0000);
    check("rst_mwdata", mwdata[0], 8'h00);
    check("rst_io", io[0], 8'h00);
    check("rst_ready1", ready[1], 1'b0);

    // first request lands on the first rising edge after reset release
    reset = 1'b0;
    xfer(0, 1'b1, 16'h1234, 8'h00);

    issue(0, 1'b0, 16'h0010, 8'h3C);
    ce_cnt[0] = 1;
    check("wr_setup_we", we[0], 1'b1);
    check("wr_setup_addr", maddr[0], 16'h0010);
    check("wr_setup_data", mwdata[0], 8'h3C);
    @(negedge clock);
    check("wr_wait_we", we[0], 1'b1);
    check("wr_wait_data", mwdata[0], 8'h3C);
    drain();
    check("wr_ce_cycles", ce_cnt[0], 4);
    xfer(0, 1'b1, 16'h0010, 8'h00);

    xfer(0, 1'b0, 16'hFFFE, 8'h11);
    xfer(0, 1'b0, 16'h0000, 8'h22);
    xfer(0, 1'b1, 16'hFFFE, 8'h00);
    xfer(0, 1'b1, 16'h0000, 8'h00);

    xfer(0, 1'b0, 16'hFFFF, 8'h5A);
    xfer(0, 1'b1, 16'hFFFF, 8'h00);

    xfer(1, 1'b1, 16'h0001, 8'h00);
    xfer(1, 1'b0, 16'h0002, 8'h77);
    xfer(1, 1'b1, 16'h0002, 8'h00);

    // requests during WAIT and during DONE must be dropped
    base = rdy_cnt[0];
    ce_cnt[0] = 0;
    issue(0, 1'b1, 16'h1234, 8'h00);
    @(posedge clock); @(negedge clock);
    req[0] = 1'b1; dir[0] = 1'b0; addr[0] = 16'h0020; wdata[0] = 8'hEE;
    @(posedge clock); #1; req[0] = 1'b0;
    check("busy_addr", maddr[0], 16'h1234);
    check("busy_we", we[0], 1'b0);
    @(negedge clock); @(negedge clock);
    req[0] = 1'b1; dir[0] = 1'b0; addr[0] = 16'h0030; wdata[0] = 8'h77;
    @(posedge clock); #1; req[0] = 1'b0;
    repeat (10) @(negedge clock);
    check("busy_ready_pulses", rdy_cnt[0] - base, 1);
    check("busy_ce_cycles", ce_cnt[0], 4);
    check("busy_mem20", sram[0][16'h0020], 8'h00);
    check("busy_mem30", sram[0][16'h0030], 8'h00);
    drain();

    // reset in the middle of a read's WAIT phase
    base = rdy_cnt[0];
    req[0] = 1'b1; dir[0] = 1'b1; addr[0] = 16'h1234;
    @(posedge clock); #1; req[0] = 1'b0;
    @(posedge clock); #2;
    check("pre_rst_ce", ce[0], 1'b1);
    reset = 1'b1;
    #1;
    check("abort_ce", ce[0], 1'b0);
    check("abort_we", we[0], 1'b0);
    check("abort_ready", ready[0], 1'b0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = '0;
      io_model[i] = '0;
    end
    repeat (8) @(negedge clock);
    check("abort_ready_pulses", rdy_cnt[0] - base, 0);
    check("abort_rdata", rdata[0], 8'h00);
    check("abort_io", io[0], 8'h00);
    xfer(0, 1'b1, 16'h0010, 8'h00);

    check("we_without_ce", we_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
